// File: rtl/axi_sram_pkg.sv
// Shared types and constants for the AXI4-to-SRAM slave controller.
// Holds the AXI channel widths, burst/response encodings and the FSM state type.
package axi_sram_pkg;

    localparam int DEFAULT_SRAM_ADDR_BITS = 14;

    localparam int AXI_ID_BITS   = 8;
    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_STRB_BITS = AXI_DATA_BITS / 8;
    localparam int AXI_LEN_BITS  = 8;
    localparam int AXI_SIZE_BITS = 3;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        R_ISSUE,
        R_DATA,
        W_DATA,
        W_RESP
    } state_t;

endpackage

// File: rtl/axi_sram_slave_if.sv
// Per-slave AXI bundle between the bridge and one slave port.
// S2AXIin carries bridge-driven signals into the slave, S2AXIout carries the slave's replies.
interface inf_Slave;
    import axi_sram_pkg::*;

    logic [AXI_ID_BITS-1:0]   awid;
    logic [AXI_ADDR_BITS-1:0] awaddr;
    logic [AXI_LEN_BITS-1:0]  awlen;
    logic [AXI_SIZE_BITS-1:0] awsize;
    logic [1:0]               awburst;
    logic                     awvalid;
    logic                     awready;

    logic [AXI_DATA_BITS-1:0] wdata;
    logic [AXI_STRB_BITS-1:0] wstrb;
    logic                     wlast;
    logic                     wvalid;
    logic                     wready;

    logic [AXI_ID_BITS-1:0]   bid;
    logic [1:0]               bresp;
    logic                     bvalid;
    logic                     bready;

    logic [AXI_ID_BITS-1:0]   arid;
    logic [AXI_ADDR_BITS-1:0] araddr;
    logic [AXI_LEN_BITS-1:0]  arlen;
    logic [AXI_SIZE_BITS-1:0] arsize;
    logic [1:0]               arburst;
    logic                     arvalid;
    logic                     arready;

    logic [AXI_ID_BITS-1:0]   rid;
    logic [AXI_DATA_BITS-1:0] rdata;
    logic [1:0]               rresp;
    logic                     rlast;
    logic                     rvalid;
    logic                     rready;

    modport S2AXIin (
        input awid, awaddr, awlen, awsize, awburst, awvalid,
        input wdata, wstrb, wlast, wvalid,
        input bready,
        input arid, araddr, arlen, arsize, arburst, arvalid,
        input rready
    );

    modport S2AXIout (
        output awready, wready,
        output bid, bresp, bvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        output rready,
        input  awready, wready, bid, bresp, bvalid,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave that turns read/write bursts into single-port synchronous SRAM accesses.
// One transaction at a time; reads take two cycles per beat, writes one cycle per beat.
module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter int SRAM_ADDR_BITS = DEFAULT_SRAM_ADDR_BITS
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    inf_Slave.S2AXIin                 s_in,
    inf_Slave.S2AXIout                s_out,
    output logic                      sram_cs,
    output logic                      sram_oe,
    output logic [3:0]                sram_web,
    output logic [SRAM_ADDR_BITS-1:0] sram_a,
    output logic [31:0]               sram_di,
    input  logic [31:0]               sram_do
);

    state_t                    state;
    state_t                    state_next;
    logic [AXI_ID_BITS-1:0]    id_q;
    logic [SRAM_ADDR_BITS-1:0] addr_q;
    logic [SRAM_ADDR_BITS-1:0] addr_next;
    logic [AXI_LEN_BITS-1:0]   len_q;
    logic [AXI_LEN_BITS-1:0]   beat_q;
    logic [1:0]                burst_q;
    logic                      aw_hs;
    logic                      ar_hs;
    logic                      last_beat;

    // Writes win a tie with reads because arready is masked by awvalid.
    assign aw_hs     = (state == IDLE) && s_in.awvalid;
    assign ar_hs     = (state == IDLE) && s_in.arvalid && !s_in.awvalid;
    assign last_beat = (beat_q == len_q);
    // WRAP bursts are deliberately handled as INCR; the address wraps silently at the top word.
    assign addr_next = (burst_q == BURST_FIXED) ? addr_q : addr_q + SRAM_ADDR_BITS'(1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (aw_hs) begin
                    state_next = W_DATA;
                end else if (ar_hs) begin
                    state_next = R_ISSUE;
                end
            end
            R_ISSUE: state_next = R_DATA;
            R_DATA: begin
                if (s_in.rready) begin
                    state_next = last_beat ? IDLE : R_ISSUE;
                end
            end
            W_DATA: begin
                if (s_in.wvalid && s_in.wlast) begin
                    state_next = W_RESP;
                end
            end
            W_RESP: begin
                if (s_in.bready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
            beat_q  <= '0;
        end else if (aw_hs) begin
            id_q    <= s_in.awid;
            addr_q  <= s_in.awaddr[SRAM_ADDR_BITS+1:2];
            len_q   <= s_in.awlen;
            burst_q <= s_in.awburst;
            beat_q  <= '0;
        end else if (ar_hs) begin
            id_q    <= s_in.arid;
            addr_q  <= s_in.araddr[SRAM_ADDR_BITS+1:2];
            len_q   <= s_in.arlen;
            burst_q <= s_in.arburst;
            beat_q  <= '0;
        end else if (state == R_DATA && s_in.rready && !last_beat) begin
            addr_q <= addr_next;
            beat_q <= beat_q + AXI_LEN_BITS'(1);
        end else if (state == W_DATA && s_in.wvalid) begin
            addr_q <= addr_next;
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a latch behind.
    always_comb begin
        s_out.awready = (state == IDLE);
        s_out.arready = (state == IDLE) && !s_in.awvalid;
        s_out.wready  = 1'b0;
        s_out.bid     = '0;
        s_out.bresp   = '0;
        s_out.bvalid  = 1'b0;
        s_out.rid     = '0;
        s_out.rdata   = '0;
        s_out.rresp   = '0;
        s_out.rlast   = 1'b0;
        s_out.rvalid  = 1'b0;
        sram_cs       = 1'b0;
        sram_oe       = 1'b0;
        sram_web      = 4'hF;
        sram_a        = '0;
        sram_di       = '0;
        case (state)
            R_ISSUE: begin
                sram_cs = 1'b1;
                sram_oe = 1'b1;
                sram_a  = addr_q;
            end
            R_DATA: begin
                // Address stays on the bus so sram_do holds steady through an R stall.
                sram_cs      = 1'b1;
                sram_oe      = 1'b1;
                sram_a       = addr_q;
                s_out.rvalid = 1'b1;
                s_out.rdata  = sram_do;
                s_out.rid    = id_q;
                s_out.rresp  = RESP_OKAY;
                s_out.rlast  = last_beat;
            end
            W_DATA: begin
                s_out.wready = 1'b1;
                if (s_in.wvalid) begin
                    sram_cs  = 1'b1;
                    sram_web = ~s_in.wstrb;
                    sram_a   = addr_q;
                    sram_di  = s_in.wdata;
                end
            end
            W_RESP: begin
                s_out.bvalid = 1'b1;
                s_out.bid    = id_q;
                s_out.bresp  = RESP_OKAY;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: directed scenarios plus random bursts against
// a word-array reference model; an independent monitor checks every R and B handshake.
module tb_axi_sram_slave;
    import axi_sram_pkg::*;

    localparam int AB    = DEFAULT_SRAM_ADDR_BITS;
    localparam int DEPTH = 1 << AB;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic          sram_cs;
    logic          sram_oe;
    logic [3:0]    sram_web;
    logic [AB-1:0] sram_a;
    logic [31:0]   sram_di;
    logic [31:0]   sram_do;

    always #5 ACLK = ~ACLK;

    inf_Slave bus();

    axi_sram_slave #(.SRAM_ADDR_BITS(AB)) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .s_in     (bus.S2AXIin),
        .s_out    (bus.S2AXIout),
        .sram_cs  (sram_cs),
        .sram_oe  (sram_oe),
        .sram_web (sram_web),
        .sram_a   (sram_a),
        .sram_di  (sram_di),
        .sram_do  (sram_do)
    );

    // Behavioural SRAM macro with a bench-only preload port.
    logic [31:0]   mem [DEPTH];
    logic          pl_en = 1'b0;
    logic [AB-1:0] pl_addr = '0;
    logic [31:0]   pl_data = '0;

    always @(posedge ACLK) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (sram_cs) begin
            if (sram_oe) sram_do <= mem[sram_a];
            for (int i = 0; i < 4; i++) begin
                if (!sram_web[i]) mem[sram_a][8*i +: 8] <= sram_di[8*i +: 8];
            end
        end
    end

    // Reference model: what memory must contain after the transactions issued so far.
    logic [31:0] ref_mem [DEPTH];

    typedef struct {
        logic [31:0] data;
        logic [7:0]  id;
        logic        last;
    } r_exp_t;

    r_exp_t      r_q[$];
    logic [7:0]  b_q[$];
    logic [31:0] wdat [16];
    logic [3:0]  wstb [16];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares every completed R/B handshake against the scoreboard queues.
    always @(negedge ACLK) begin
        if (ARESETn) begin
            if (bus.rvalid && bus.rready) begin
                if (r_q.size() == 0) begin
                    check("r_unexpected", 32'(1), 32'(0));
                end else begin
                    r_exp_t e;
                    e = r_q.pop_front();
                    check("rdata", bus.rdata, e.data);
                    check("rid", 32'(bus.rid), 32'(e.id));
                    check("rlast", 32'(bus.rlast), 32'(e.last));
                    check("rresp", 32'(bus.rresp), 32'(RESP_OKAY));
                end
            end
            if (bus.bvalid && bus.bready) begin
                if (b_q.size() == 0) begin
                    check("b_unexpected", 32'(1), 32'(0));
                end else begin
                    logic [7:0] eid;
                    eid = b_q.pop_front();
                    check("bid", 32'(bus.bid), 32'(eid));
                    check("bresp", 32'(bus.bresp), 32'(RESP_OKAY));
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [AB-1:0] word, input logic [31:0] data);
        pl_en   = 1'b1;
        pl_addr = word;
        pl_data = data;
        ref_mem[word] = data;
        @(posedge ACLK); #1;
        pl_en = 1'b0;
    endtask

    task automatic send_aw(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [7:0] id, input bit expect_b);
        int n = 0;
        if (expect_b) b_q.push_back(id);
        bus.awaddr  = addr;
        bus.awlen   = len;
        bus.awburst = burst;
        bus.awid    = id;
        bus.awsize  = 3'd2;
        bus.awvalid = 1'b1;
        do begin @(negedge ACLK); n++; end while (!bus.awready && n < 50);
        if (!bus.awready) check("aw_timeout", 32'(0), 32'(1));
        @(posedge ACLK); #1;
        bus.awvalid = 1'b0;
    endtask

    // Sends nbeats of a burst whose full length is total beats; wlast only on beat total-1.
    task automatic send_w(input logic [31:0] addr, input logic [1:0] burst, input int nbeats, input int total);
        logic [AB-1:0] w;
        w = addr[AB+1:2];
        for (int b = 0; b < nbeats; b++) begin
            int n = 0;
            bus.wvalid = 1'b1;
            bus.wdata  = wdat[b];
            bus.wstrb  = wstb[b];
            bus.wlast  = (b == total - 1);
            do begin @(negedge ACLK); n++; end while (!bus.wready && n < 50);
            if (!bus.wready) begin
                check("w_timeout", 32'(0), 32'(1));
                break;
            end
            if (b == 0) check("w_first_latency", 32'(n), 32'(1));
            @(posedge ACLK);
            for (int i = 0; i < 4; i++) begin
                if (wstb[b][i]) ref_mem[w][8*i +: 8] = wdat[b][8*i +: 8];
            end
            if (burst != BURST_FIXED) w = w + 1'b1;
            #1;
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
    endtask

    task automatic wait_b();
        int n = 0;
        bus.bready = 1'b1;
        do begin @(negedge ACLK); n++; end while (!bus.bvalid && n < 50);
        check("b_latency", 32'(n), 32'(1));
        @(posedge ACLK); #1;
        bus.bready = 1'b0;
        check("awready_after_b", 32'(bus.awready), 32'(1));
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [7:0] id);
        int n = 0;
        logic [AB-1:0] w;
        w = addr[AB+1:2];
        for (int i = 0; i <= int'(len); i++) begin
            r_exp_t e;
            e.data = ref_mem[w];
            e.id   = id;
            e.last = (i == int'(len));
            r_q.push_back(e);
            if (burst != BURST_FIXED) w = w + 1'b1;
        end
        bus.araddr  = addr;
        bus.arlen   = len;
        bus.arburst = burst;
        bus.arid    = id;
        bus.arsize  = 3'd2;
        bus.arvalid = 1'b1;
        do begin @(negedge ACLK); n++; end while (!bus.arready && n < 50);
        if (!bus.arready) check("ar_timeout", 32'(0), 32'(1));
        @(posedge ACLK); #1;
        bus.arvalid = 1'b0;
    endtask

    // Accepts len+1 beats; on stall_beat rready is held low for three cycles first.
    task automatic recv_r(input int len, input int stall_beat, input bit check_lat);
        logic [31:0] held;
        for (int b = 0; b <= len; b++) begin
            int n = 0;
            bus.rready = (b != stall_beat);
            do begin @(negedge ACLK); n++; end while (!bus.rvalid && n < 50);
            if (!bus.rvalid) begin
                check("r_timeout", 32'(0), 32'(1));
                break;
            end
            if (b == 0 && check_lat) check("r_latency", 32'(n), 32'(2));
            if (b == stall_beat) begin
                held = bus.rdata;
                repeat (3) begin
                    @(negedge ACLK);
                    check("stall_rvalid", 32'(bus.rvalid), 32'(1));
                    check("stall_rdata", bus.rdata, held);
                end
                @(posedge ACLK); #1;
                bus.rready = 1'b1;
                @(negedge ACLK);
            end
            @(posedge ACLK); #1;
        end
        bus.rready = 1'b0;
    endtask

    initial begin
        int bad;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arvalid = 1'b0;
        bus.rready = 1'b0;

        repeat (3) @(posedge ACLK);
        #1;
        check("rst_awready", 32'(bus.awready), 32'(1));
        check("rst_arready", 32'(bus.arready), 32'(1));
        check("rst_valids", 32'({bus.wready, bus.bvalid, bus.rvalid, bus.rlast}), 32'(0));
        check("rst_ids_resp", 32'({bus.rid, bus.bid, bus.rresp, bus.bresp}), 32'(0));
        check("rst_rdata", bus.rdata, 32'(0));
        check("rst_sram_ctl", 32'({sram_cs, sram_oe, sram_web}), 32'h0000000F);

        // Fill the SRAM and reference with identical random contents while in reset.
        pl_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            pl_addr = AB'(i);
            pl_data = $urandom;
            ref_mem[i] = pl_data;
            @(posedge ACLK); #1;
        end
        pl_en = 1'b0;
        ARESETn = 1'b1;
        @(posedge ACLK); #1;

        // Single read
        preload(AB'(16'h10), 32'hDEADBEEF);
        send_ar(32'h40, 8'd0, BURST_INCR, 8'h05);
        recv_r(0, 99, 1'b1);

        // INCR write then read-back
        wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
        for (int i = 0; i < 4; i++) wstb[i] = 4'hF;
        send_aw(32'h100, 8'd3, BURST_INCR, 8'h3C, 1'b1);
        send_w(32'h100, BURST_INCR, 4, 4);
        wait_b();
        for (int i = 0; i < 4; i++) check("incr_write_word", mem[16'h40 + i], 32'h11 * (i + 1));
        send_ar(32'h100, 8'd3, BURST_INCR, 8'h21);
        recv_r(3, 99, 1'b0);

        // Byte strobes
        preload(AB'(16'h20), 32'hFFFFFFFF);
        wdat[0] = 32'h12345678; wstb[0] = 4'b0101;
        send_aw(32'h80, 8'd0, BURST_INCR, 8'h01, 1'b1);
        send_w(32'h80, BURST_INCR, 1, 1);
        wait_b();
        check("strobe_word", mem[16'h20], 32'hFF34FF78);

        // FIXED read with a stall on beat 2
        send_ar(32'h200, 8'd2, BURST_FIXED, 8'h44);
        recv_r(2, 1, 1'b0);

        // Simultaneous AW and AR: write goes first, read waits for B
        wdat[0] = 32'hA5A50001; wdat[1] = 32'h5A5A0002; wstb[0] = 4'hF; wstb[1] = 4'hC;
        bus.araddr = 32'h400; bus.arlen = 8'd1; bus.arburst = BURST_INCR; bus.arid = 8'h0B;
        bus.arvalid = 1'b1;
        b_q.push_back(8'h0A);
        bus.awaddr = 32'h400; bus.awlen = 8'd1; bus.awburst = BURST_INCR; bus.awid = 8'h0A;
        bus.awvalid = 1'b1;
        @(negedge ACLK);
        check("both_awready", 32'(bus.awready), 32'(1));
        check("both_arready", 32'(bus.arready), 32'(0));
        @(posedge ACLK); #1;
        bus.awvalid = 1'b0;
        check("arready_in_wdata", 32'(bus.arready), 32'(0));
        send_w(32'h400, BURST_INCR, 2, 2);
        check("arready_in_wresp", 32'(bus.arready), 32'(0));
        wait_b();
        check("arready_after_b", 32'(bus.arready), 32'(1));
        send_ar(32'h400, 8'd1, BURST_INCR, 8'h0B);
        recv_r(1, 99, 1'b0);

        // INCR read wrapping from the top word to word 0
        send_ar(32'h0000FFFC, 8'd2, BURST_INCR, 8'h66);
        recv_r(2, 99, 1'b0);

        // Reset mid-write: abandon after beat 2 of 4
        for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        send_aw(32'h300, 8'd3, BURST_INCR, 8'h77, 1'b0);
        send_w(32'h300, BURST_INCR, 2, 4);
        bus.wvalid = 1'b1; bus.wdata = wdat[2]; bus.wstrb = 4'hF;
        ARESETn = 1'b0;
        #1;
        check("abort_sram_cs", 32'(sram_cs), 32'(0));
        check("abort_valids", 32'({bus.wready, bus.bvalid, bus.rvalid}), 32'(0));
        bus.wvalid = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        bus.bready = 1'b1;
        repeat (4) begin
            @(negedge ACLK);
            check("abort_no_b", 32'(bus.bvalid), 32'(0));
        end
        check("abort_awready", 32'(bus.awready), 32'(1));
        check("abort_beat3_unwritten", mem[16'hC2], ref_mem[16'hC2]);
        @(posedge ACLK); #1;
        bus.bready = 1'b0;

        // Randomised bursts
        for (int t = 0; t < 24; t++) begin
            logic [31:0] addr;
            logic [7:0]  len;
            logic [1:0]  burst;
            logic [7:0]  id;
            addr  = $urandom;
            len   = 8'($urandom_range(0, 7));
            burst = 2'($urandom_range(0, 2));
            id    = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= int'(len); i++) begin
                    wdat[i] = $urandom;
                    wstb[i] = 4'($urandom);
                end
                send_aw(addr, len, burst, id, 1'b1);
                send_w(addr, burst, int'(len) + 1, int'(len) + 1);
                wait_b();
            end else begin
                send_ar(addr, len, burst, id);
                recv_r(int'(len), ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, int'(len))) : 99, 1'b0);
            end
        end

        repeat (4) @(posedge ACLK);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("mem_image_mismatches", 32'(bad), 32'(0));
        check("r_queue_left", 32'(r_q.size()), 32'(0));
        check("b_queue_left", 32'(b_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
